// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-channel TDM serial receiver rebuilding o0..o3 from one wire
// Define TDM_PARITY_EN to add a trailing one-bit even-parity slot per frame.
module tdm_demux4 #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync,
  input  logic              d,
  output logic [DATA_W-1:0] o0,
  output logic [DATA_W-1:0] o1,
  output logic [DATA_W-1:0] o2,
  output logic [DATA_W-1:0] o3,
  output logic [1:0]        s,
  output logic              valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        s_q, s_d;
  logic [DATA_W-1:0] stg_q [4];
  logic [DATA_W-1:0] stg_d [4];
  logic [DATA_W-1:0] out_q [4];
  logic [DATA_W-1:0] out_d [4];
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;

  logic              start;
  logic              take_bit;
  logic              frame_end;
  logic [DATA_W-1:0] shift_w;
  logic [CW-1:0]     cnt_w;
  logic [1:0]        slot;
`ifdef TDM_PARITY_EN
  logic              par_q, par_d;
  logic              par_bad;
`endif

  assign start = en & sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A qualified sync always (re)starts a frame, even mid-frame.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RECV;
    end else if (frame_end) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    s_d       = s_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    frame_end = 1'b0;
    take_bit  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stg_d[i] = stg_q[i];
      out_d[i] = out_q[i];
    end
    shift_w = (shift_q << 1) | DATA_W'(d);
    cnt_w   = cnt_q + CW'(1);
    slot    = s_q;
`ifdef TDM_PARITY_EN
    par_d   = par_q;
    par_bad = 1'b0;
`endif

    if (start) begin
      ferr_d   = (state_q == RECV);
      take_bit = 1'b1;
      shift_w  = DATA_W'(d);
      cnt_w    = CW'(1);
      slot     = 2'd0;
      for (int i = 0; i < 4; i++) begin
        stg_d[i] = '0;
      end
`ifdef TDM_PARITY_EN
      par_d = 1'b0;
`endif
    end else if (en && state_q == RECV) begin
`ifdef TDM_PARITY_EN
      if (par_q) begin
        par_bad   = (^stg_q[0]) ^ (^stg_q[1]) ^ (^stg_q[2]) ^ (^stg_q[3]) ^ d;
        par_d     = 1'b0;
        frame_end = 1'b1;
        if (par_bad) begin
          ferr_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          for (int i = 0; i < 4; i++) begin
            out_d[i] = stg_q[i];
          end
        end
      end else begin
        take_bit = 1'b1;
      end
`else
      take_bit = 1'b1;
`endif
    end

    if (take_bit) begin
      shift_d = shift_w;
      cnt_d   = cnt_w;
      s_d     = slot;
      if (cnt_w == CW'(DATA_W)) begin
        stg_d[slot] = shift_w;
        cnt_d       = '0;
        s_d         = slot + 2'd1;
        if (slot == 2'd3) begin
`ifdef TDM_PARITY_EN
          par_d = 1'b1;
`else
          valid_d   = 1'b1;
          frame_end = 1'b1;
          for (int i = 0; i < 4; i++) begin
            out_d[i] = stg_d[i];
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      s_q     <= 2'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        stg_q[i] <= '0;
        out_q[i] <= '0;
      end
`ifdef TDM_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      for (int i = 0; i < 4; i++) begin
        stg_q[i] <= stg_d[i];
        out_q[i] <= out_d[i];
      end
`ifdef TDM_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    o0        = out_q[0];
    o1        = out_q[1];
    o2        = out_q[2];
    o3        = out_q[3];
    s         = s_q;
    valid     = valid_q;
    frame_err = ferr_q;
    busy      = (state_q == RECV);
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive end of the single-wire 4:1 select path: takes one serial wire carrying four time-multiplexed channels and rebuilds the four channel words.
- An internal 2-bit slot counter plays the role of the mux select lines (s1,s0); slot k carries channel ik.
- Completed frames are presented on o0..o3 together with a one-cycle valid pulse.
- Sits downstream of the mux circuit as its deserializing/demultiplexing counterpart.

Parameters:
- DATA_W, 1, bits per channel per frame, sent MSB first; legal range 1..16.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  bit-sample enable; d and sync are ignored when en=0.
- sync  input  1  frame start; qualified by en; marks the first bit of slot 0.
- d  input  1  serial data wire.
- o0  output  DATA_W  channel 0 word (slot 0).
- o1  output  DATA_W  channel 1 word (slot 1).
- o2  output  DATA_W  channel 2 word (slot 2).
- o3  output  DATA_W  channel 3 word (slot 3).
- s  output  2  current slot; s[1]=s1, s[0]=s0.
- valid  output  1  one-cycle pulse: new frame on o0..o3.
- frame_err  output  1  one-cycle pulse: frame aborted or rejected.
- busy  output  1  high while in RECV.

Behaviour:
- Reset (rst_n=0 at a clk edge): o0..o3=0, s=0, valid=0, frame_err=0, busy=0, state=IDLE, bit counter=0, shift and staging registers=0.
- Reset takes priority over all other inputs; a reset mid-frame discards the partial frame without a frame_err pulse.
- States: IDLE, RECV.
- IDLE:
  - en & sync: shift d into bit 0 of the shift register; bit counter=1, s=0, go RECV.
  - If DATA_W=1, slot 0 completes in this same cycle (slot-completion rule below).
  - Otherwise hold.
- RECV, per en=1 cycle:
  - shift = {shift[DATA_W-2:0], d}; bit counter increments.
  - Slot completion: when the bit counter reaches DATA_W, write the completed word to staging[s], clear the bit counter, increment s (wraps 3->0).
  - Frame completion: completing slot 3 copies staging to o0..o3 in one edge, pulses valid on the next cycle, returns to IDLE, and sets s=0.
- RECV, en=0: all state holds, with no sampling or counting.
- en & sync while in RECV (resync):
  - pulse frame_err; discard staging; o0..o3 unchanged.
  - treat the current d as bit 0 of slot 0 of a new frame.
- sync while en=0: ignored.
- Latency: exactly 4*DATA_W en-qualified samples from the sync bit to the last bit. valid rises one clk after the edge that samples the last bit. o0..o3 are stable from that edge until the next frame completes.
- valid and frame_err are never high in the same cycle.
- Back-to-back frames: a sync in the cycle right after frame completion is accepted with no gap.

Optional Feature:
- Macro TDM_PARITY_EN.
- Defined:
  - a fifth slot of one bit follows slot 3; s reads 0 during it; busy stays high.
  - The bit is even parity of all 4*DATA_W data bits: XOR of the data bits and the parity bit must equal 0.
  - Match: outputs update and valid pulses.
  - Mismatch: o0..o3 are unchanged and frame_err pulses instead of valid.
  - Total frame length is 4*DATA_W+1 samples.
- Undefined: no parity slot; the frame ends after slot 3, as described above.

Test Plan:
- DATA_W=1; en=1; sync with d=1, then d=0,1,0 -> o0..o3=1,0,1,0; valid pulses once, 1 clk after the 4th sample; s read 0,1,2,3 during the frame.
- DATA_W=4; frame with words A,5,C,3 (MSB first), en toggled 1/0 every cycle -> o0..o3 = 4'hA,4'h5,4'hC,4'h3; valid after 16 enabled samples; nothing advances on en=0 cycles.
- Resync: after 2 slots of a DATA_W=1 frame, assert sync with d=0, then d=1,1,1 -> frame_err pulses once; o0..o3 = 0,1,1,1; valid pulses once.
- Reset mid-frame: rst_n=0 after slot 1 -> next edge: all outputs 0, busy=0, no valid, no frame_err; the next full frame decodes correctly.
- Back-to-back frames 1,0,1,0 then 0,1,0,1 with no gap -> two valid pulses exactly 4 cycles apart; the second shows o0..o3 = 0,1,0,1.
- TDM_PARITY_EN, DATA_W=1:
  - data 1,0,1,0 with parity 0 -> valid.
  - same data with parity 1 -> frame_err; o0..o3 keep their previous values.
